// File: rtl/pt_dec_if.sv
// rtl/pt_dec_if.sv - serial line in, decoded word and strobes out
// The encoder side drives din; the decoder side returns code/valid/err.
interface pt_dec_if;
   logic        din;
   logic [23:0] code;
   logic        valid;
   logic        err;

   modport master (output din, input code, input valid, input err);
   modport slave  (input din, output code, output valid, output err);
endinterface

// File: rtl/pt_dec.sv
// rtl/pt_dec.sv - PT2262-style tri-state pulse train decoder
// Measures high/low run lengths, decodes 12-trit frames and accepts a word after two identical frames.
module pt_dec #(
   parameter int SHORT_MIN = 2,
   parameter int SHORT_MAX = 7,
   parameter int LONG_MAX  = 15,
   parameter int SYNC_MIN  = 64
) (
   input  logic     clk,
   input  logic     rst_n,
   pt_dec_if.slave  io_bus
);

   typedef enum logic {HUNT, COLLECT} state_t;

   localparam logic [7:0] L_SMIN    = 8'(SHORT_MIN);
   localparam logic [7:0] L_SMAX    = 8'(SHORT_MAX);
   localparam logic [7:0] L_LMAX    = 8'(LONG_MAX);
   localparam logic [7:0] L_SYNC    = 8'(SYNC_MIN);
   localparam logic [7:0] L_SYNC_M1 = 8'(SYNC_MIN - 1);

   logic [1:0]  r_sync;
   logic [7:0]  r_hi_cnt;
   logic [7:0]  r_lo_cnt;
   logic [7:0]  r_hi_w;
   state_t      r_state;
   logic [23:0] r_frame;
   logic [23:0] r_prev;
   logic [23:0] r_code;
   logic        r_prev_ok;
   logic [4:0]  r_half_cnt;
   logic        r_valid;
   logic        r_err;

   logic w_ds;
   logic w_rise;
   logic w_fall;
   logic w_gap_end;
   logic w_sync;
   logic w_hi_over;
   logic w_pair_ok;
   logic w_half;
   logic w_bad_trit;

   function automatic logic is_short(input logic [7:0] w);
      return (w >= L_SMIN) && (w <= L_SMAX);
   endfunction

   function automatic logic is_long(input logic [7:0] w);
      return (w > L_SMAX) && (w <= L_LMAX);
   endfunction

   assign w_ds      = r_sync[1];
   assign w_rise    = w_ds & (r_lo_cnt != 8'd0);
   assign w_fall    = ~w_ds & (r_hi_cnt != 8'd0);
   // A rising edge that ends a sync gap is not a pulse pair; the gap was handled by w_sync.
   assign w_gap_end = (r_lo_cnt >= L_SYNC);
   assign w_sync    = ~w_ds & (r_lo_cnt == L_SYNC_M1);
   assign w_hi_over = w_ds & (r_hi_cnt == L_LMAX);
   assign w_pair_ok = (is_short(r_hi_w) & is_long(r_lo_cnt)) |
                      (is_long(r_hi_w) & is_short(r_lo_cnt));
   assign w_half    = is_long(r_hi_w);
   assign w_bad_trit = r_half_cnt[0] & r_frame[0] & ~w_half;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= 2'b00;
         r_hi_cnt <= 8'd0;
         r_lo_cnt <= 8'd0;
         r_hi_w   <= 8'd0;
      end else begin
         r_sync <= {r_sync[0], io_bus.din};
         if (w_ds) begin
            r_hi_cnt <= (r_hi_cnt == 8'hFF) ? r_hi_cnt : r_hi_cnt + 8'd1;
            r_lo_cnt <= 8'd0;
         end else begin
            r_lo_cnt <= (r_lo_cnt == 8'hFF) ? r_lo_cnt : r_lo_cnt + 8'd1;
            r_hi_cnt <= 8'd0;
         end
         if (w_fall) begin
            r_hi_w <= r_hi_cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= HUNT;
         r_frame    <= 24'd0;
         r_prev     <= 24'd0;
         r_code     <= 24'd0;
         r_prev_ok  <= 1'b0;
         r_half_cnt <= 5'd0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_sync && !is_short(r_hi_w)) begin
            r_state   <= HUNT;
            r_prev_ok <= 1'b0;
         end else begin
            case (r_state)
               HUNT: begin
                  if (w_sync) begin
                     r_half_cnt <= 5'd0;
                     r_state    <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (w_sync) begin
                     r_half_cnt <= 5'd0;
                     if (r_half_cnt == 5'd24) begin
                        if (r_prev_ok && (r_frame == r_prev)) begin
                           r_code  <= r_frame;
                           r_valid <= 1'b1;
                        end
                        r_prev    <= r_frame;
                        r_prev_ok <= 1'b1;
                     end else begin
                        r_err     <= 1'b1;
                        r_prev_ok <= 1'b0;
                     end
                  end else if (w_hi_over) begin
                     r_err     <= 1'b1;
                     r_prev_ok <= 1'b0;
                     r_state   <= HUNT;
                  end else if (w_rise && !w_gap_end) begin
                     if (!w_pair_ok || (r_half_cnt == 5'd24) || w_bad_trit) begin
                        r_err     <= 1'b1;
                        r_prev_ok <= 1'b0;
                        r_state   <= HUNT;
                     end else begin
                        r_frame    <= {r_frame[22:0], w_half};
                        r_half_cnt <= r_half_cnt + 5'd1;
                     end
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

   assign io_bus.code  = r_code;
   assign io_bus.valid = r_valid;
   assign io_bus.err   = r_err;

endmodule

// File: tb/tb_pt_dec.sv
// tb/tb_pt_dec.sv - directed bench for pt_dec with a symbol-level reference model
module tb_pt_dec;
   localparam int SMIN = 2;
   localparam int SMAX = 7;
   localparam int LMAX = 15;
   localparam int SYNC = 64;
   localparam int MAXC = 32768;
   localparam logic [23:0] W1   = 24'h34000F;
   localparam logic [23:0] W2   = 24'h34300F;
   localparam logic [23:0] WBAD = 24'h38000F;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pt_dec_if bus ();

   pt_dec #(.SHORT_MIN(SMIN), .SHORT_MAX(SMAX), .LONG_MAX(LMAX), .SYNC_MIN(SYNC)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          exp_v [MAXC];
   bit          exp_e [MAXC];
   logic [23:0] exp_c [MAXC];
   logic [23:0] model_code = 24'd0;
   int          checks = 0;
   int          errors = 0;
   int          n_valid = 0;
   int          n_err = 0;

   bit          m_collect = 1'b0;
   bit          m_prev_ok = 1'b0;
   logic [23:0] m_prev = 24'd0;
   bit          m_halves[$];
   int          prev_h = 0;
   int          prev_l = 0;
   int          mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 30) $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_s(input int w);
      return (w >= SMIN) && (w <= SMAX);
   endfunction

   function automatic bit is_l(input int w);
      return (w > SMAX) && (w <= LMAX);
   endfunction

   task automatic m_hunt();
      m_collect = 1'b0;
      m_prev_ok = 1'b0;
      m_halves.delete();
   endtask

   task automatic sched_err(input int t);
      if (t < MAXC) exp_e[t] = 1'b1;
   endtask

   // Pair ending at a rising edge; decision visible 3 cycles after din rises (2 sync flops + register).
   task automatic model_rise(input int h, input int l, input int t);
      bit b;
      if (l >= SYNC || !m_collect) return;
      if (is_s(h) && is_l(l)) b = 1'b0;
      else if (is_l(h) && is_s(l)) b = 1'b1;
      else begin sched_err(t); m_hunt(); return; end
      if (m_halves.size() == 24) begin sched_err(t); m_hunt(); return; end
      if ((m_halves.size() % 2 == 1) && m_halves[$] == 1'b1 && b == 1'b0) begin
         sched_err(t); m_hunt(); return;
      end
      m_halves.push_back(b);
   endtask

   task automatic model_hiover(input int t);
      if (m_collect) begin sched_err(t); m_hunt(); end
   endtask

   task automatic model_sync(input int h, input int t);
      logic [23:0] word;
      if (!is_s(h)) begin m_hunt(); return; end
      if (!m_collect) begin m_collect = 1'b1; m_halves.delete(); return; end
      if (m_halves.size() == 24) begin
         for (int k = 0; k < 24; k++) word[23-k] = m_halves[k];
         if (m_prev_ok && word == m_prev && t < MAXC) begin
            exp_v[t] = 1'b1;
            exp_c[t] = word;
         end
         m_prev = word;
         m_prev_ok = 1'b1;
      end else begin
         sched_err(t);
         m_prev_ok = 1'b0;
      end
      m_halves.delete();
   endtask

   task automatic pulse(input int h, input int l);
      model_rise(prev_h, prev_l, cyc + 3);
      bus.din = 1'b1;
      if (h > LMAX) model_hiover(cyc + 3 + LMAX);
      repeat (h) @(posedge clk);
      #1;
      if (l >= SYNC) model_sync(h, cyc + 2 + SYNC);
      bus.din = 1'b0;
      repeat (l) @(posedge clk);
      #1;
      prev_h = h;
      prev_l = l;
   endtask

   task automatic send_half(input bit b);
      int s, lg;
      case (mode)
         1:       begin s = 7; lg = 8;  end
         2:       begin s = 2; lg = 15; end
         default: begin s = 4; lg = 12; end
      endcase
      if (b) pulse(lg, s);
      else   pulse(s, lg);
   endtask

   task automatic send_sync();
      pulse(4, 124);
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_code", {8'd0, bus.code}, 32'd0);
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      for (int i = cyc; i < MAXC; i++) begin
         exp_v[i] = 1'b0;
         exp_e[i] = 1'b0;
      end
      m_hunt();
      prev_h = 0;
      prev_l = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send_word(input logic [23:0] w, input int n, input int bad_idx, input int rst_at);
      bit b;
      for (int k = 0; k < n; k++) begin
         if (k == rst_at) mid_reset();
         b = (k < 24) ? w[23-k] : 1'b0;
         if (k == bad_idx) pulse(20, 12);
         else send_half(b);
      end
   endtask

   task automatic frame(input logic [23:0] w);
      send_word(w, 24, -1, -1);
      send_sync();
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_code = 24'd0;
         end else begin
            if (cyc < MAXC && exp_v[cyc]) model_code = exp_c[cyc];
            chk("valid", {31'd0, bus.valid}, {31'd0, (cyc < MAXC) ? exp_v[cyc] : 1'b0});
            chk("err", {31'd0, bus.err}, {31'd0, (cyc < MAXC) ? exp_e[cyc] : 1'b0});
            chk("code", {8'd0, bus.code}, {8'd0, model_code});
            if (bus.valid) n_valid++;
            if (bus.err) n_err++;
         end
      end
   endtask

   int v0, e0;

   initial begin
      bus.din = 1'b0;
      fork
         compare_loop();
      join_none
      repeat (4) @(posedge clk);
      #1;
      chk("init_code", {8'd0, bus.code}, 32'd0);
      chk("init_valid", {31'd0, bus.valid}, 32'd0);
      chk("init_err", {31'd0, bus.err}, 32'd0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;

      v0 = n_valid; e0 = n_err;
      send_sync();
      frame(W1);
      frame(W1);
      chk("a_valids", n_valid - v0, 1);
      chk("a_errs", n_err - e0, 0);
      chk("a_code", {8'd0, bus.code}, {8'd0, W1});

      v0 = n_valid; e0 = n_err;
      frame(W2);
      chk("b_first_valids", n_valid - v0, 0);
      frame(W2);
      chk("b_valids", n_valid - v0, 1);
      chk("b_errs", n_err - e0, 0);
      chk("b_code", {8'd0, bus.code}, {8'd0, W2});

      v0 = n_valid; e0 = n_err;
      send_word(W1, 24, 6, -1);
      send_sync();
      frame(W1);
      chk("c_next_valids", n_valid - v0, 0);
      frame(W1);
      chk("c_valids", n_valid - v0, 1);
      chk("c_errs", n_err - e0, 1);

      v0 = n_valid; e0 = n_err;
      send_word(W1, 22, -1, -1);
      send_sync();
      frame(W1);
      frame(W1);
      chk("d_valids", n_valid - v0, 1);
      chk("d_errs", n_err - e0, 1);

      v0 = n_valid; e0 = n_err;
      frame(WBAD);
      frame(W1);
      frame(W1);
      chk("e_valids", n_valid - v0, 1);
      chk("e_errs", n_err - e0, 1);

      v0 = n_valid; e0 = n_err;
      send_word(W1, 24, -1, 13);
      send_sync();
      frame(W1);
      chk("f_code_held", {8'd0, bus.code}, 32'd0);
      frame(W1);
      chk("f_valids", n_valid - v0, 1);
      chk("f_code", {8'd0, bus.code}, {8'd0, W1});

      v0 = n_valid; e0 = n_err;
      send_word(W1, 25, -1, -1);
      send_sync();
      chk("g_errs", n_err - e0, 1);
      chk("g_valids", n_valid - v0, 0);

      v0 = n_valid; e0 = n_err;
      mode = 1;
      frame(W2);
      mode = 2;
      frame(W2);
      mode = 0;
      chk("h_valids", n_valid - v0, 1);
      chk("h_errs", n_err - e0, 0);
      chk("h_code", {8'd0, bus.code}, {8'd0, W2});

      repeat (10) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
